// File: rtl/button_debouncer.sv
// Per-channel button debouncer: two-flop synchronizer, a per-channel 24-bit
// acceptance counter, and registered one-cycle rise/fall pulses.
module button_debouncer #(
    parameter int unsigned WIDTH           = 8,
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd100_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_rise,
    output logic [WIDTH-1:0] btn_fall
);

    localparam logic [23:0] LAST_COUNT = DEBOUNCE_CYCLES - 24'd1;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [23:0]      r_cnt [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // Synchronizers keep sampling even while disabled.
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (!ena || (r_sync2[i] == r_level[i])) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LAST_COUNT) begin
                    r_level[i] <= r_sync2[i];
                    r_rise[i]  <= r_sync2[i];
                    r_fall[i]  <= ~r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 24'd1;
                end
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;
    assign btn_fall  = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random traffic, checked
// against a sliding-window model of the acceptance rule.
module tb_button_debouncer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ena;
    logic [W-1:0] btn_in;
    logic [W-1:0] btn_level;
    logic [W-1:0] btn_rise;
    logic [W-1:0] btn_fall;

    int compared   = 0;
    int mismatched = 0;

    // Model: input delayed two edges, plus the last D (sample, enabled) pairs.
    logic [W-1:0] m_p1, m_p2, m_level, m_rise, m_fall;
    logic [W-1:0] win_s [D];
    logic         win_v [D];

    always #5 clk = ~clk;

    button_debouncer #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(24'd4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_rise(btn_rise),
        .btn_fall(btn_fall)
    );

    function automatic void model_reset();
        m_p1 = '0; m_p2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        for (int j = 0; j < D; j++) begin
            win_s[j] = '0;
            win_v[j] = 1'b0;
        end
    endfunction

    // A channel is accepted when its last D sampled values all differ from
    // the stable level and every one of those edges was enabled.
    function automatic void model_edge();
        logic [W-1:0] s;
        logic         ok;
        s    = m_p2;
        m_p2 = m_p1;
        m_p1 = btn_in;
        for (int j = D - 1; j > 0; j--) begin
            win_s[j] = win_s[j-1];
            win_v[j] = win_v[j-1];
        end
        win_s[0] = s;
        win_v[0] = ena;
        m_rise = '0;
        m_fall = '0;
        for (int c = 0; c < W; c++) begin
            ok = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (!win_v[j] || (win_s[j][c] == m_level[c])) ok = 1'b0;
            end
            if (ok) begin
                m_level[c] = s[c];
                if (s[c]) m_rise[c] = 1'b1;
                else      m_fall[c] = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".level"}, btn_level, m_level);
        chk({tag, ".rise"},  btn_rise,  m_rise);
        chk({tag, ".fall"},  btn_fall,  m_fall);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        #1;
        chk_model(tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int t = 0; t < n; t++) tick(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, ".level"}, btn_level, 8'h00);
        chk({tag, ".rise"},  btn_rise,  8'h00);
        chk({tag, ".fall"},  btn_fall,  8'h00);
        model_reset();
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        btn_in = 8'hFF;
        model_reset();
        #1;
        chk("por.level", btn_level, 8'h00);
        chk("por.rise",  btn_rise,  8'h00);
        chk("por.fall",  btn_fall,  8'h00);
        ticks("por", 2);
        btn_in = 8'h00;
        rst_n  = 1'b1;
        ticks("idle", 4);

        // Single-channel rise: accepted on the sixth edge after the change.
        btn_in = 8'h01;
        ticks("s2.wait", 5);
        chk("s2.level_early", btn_level, 8'h00);
        tick("s2.accept");
        chk("s2.level", btn_level, 8'h01);
        chk("s2.rise",  btn_rise,  8'h01);
        tick("s2.after");
        chk("s2.rise_clear", btn_rise, 8'h00);
        btn_in = 8'h00;
        ticks("s2.fall", 8);

        // Short glitches on channel 3 never get accepted.
        for (int r = 0; r < 5; r++) begin
            btn_in = 8'h08;
            ticks("s3.hi", 3);
            btn_in = 8'h00;
            ticks("s3.lo", 3);
        end
        ticks("s3.settle", 4);
        chk("s3.level", btn_level, 8'h00);

        // Multi-channel rise then fall.
        btn_in = 8'hA5;
        ticks("s4.wait", 5);
        tick("s4.accept");
        chk("s4.rise",  btn_rise,  8'hA5);
        chk("s4.level", btn_level, 8'hA5);
        tick("s4.after");
        chk("s4.rise_clear", btn_rise, 8'h00);
        btn_in = 8'h00;
        ticks("s4.fwait", 5);
        tick("s4.faccept");
        chk("s4.fall", btn_fall, 8'hA5);
        tick("s4.fafter");

        // Asynchronous reset with no clock edge required.
        btn_in = 8'hFF;
        ticks("s1.pre", 7);
        chk("s1.level_pre", btn_level, 8'hFF);
        async_reset("s1");
        tick("s1.hold");
        btn_in = 8'h00;
        rst_n  = 1'b1;
        ticks("s1.post", 4);

        // Disabled: counters held, level frozen; restart counts from zero.
        ena    = 1'b0;
        btn_in = 8'h02;
        ticks("s5.off", 20);
        chk("s5.level_off", btn_level, 8'h00);
        ena = 1'b1;
        ticks("s5.on", 3);
        tick("s5.accept");
        chk("s5.rise", btn_rise, 8'h02);
        btn_in = 8'h00;
        ticks("s5.fall", 8);

        // Reset mid-count aborts; full latency after release.
        btn_in = 8'h04;
        ticks("s6.count", 4);
        async_reset("s6");
        tick("s6.hold");
        rst_n = 1'b1;
        ticks("s6.wait", 5);
        chk("s6.no_rise", btn_rise, 8'h00);
        tick("s6.accept");
        chk("s6.rise", btn_rise, 8'h04);
        btn_in = 8'h00;
        ticks("s6.fall", 8);

        // Random traffic: holds, glitches, enable drops and resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) btn_in = btn_in ^ W'($urandom);
            ena = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd.rst");
                tick("rnd.rst_hold");
                rst_n = 1'b1;
            end else begin
                tick("rnd");
                chk("rnd.excl", btn_rise & btn_fall, 8'h00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
